// File: rtl/fifo_rr_wr_arbiter.sv
// rtl/fifo_rr_wr_arbiter.sv - round-robin arbiter sharing one FIFO write port among NUM_REQ producers
module fifo_rr_wr_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int DATA_W       = 8,
    parameter int MAX_BURST    = 4,
    parameter int IDLE_TIMEOUT = 8,
    localparam int GW          = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_last,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic                      fifo_full,
    output logic                      fifo_wr_en,
    output logic [DATA_W-1:0]         fifo_wr_data,
    output logic [GW-1:0]             grant_id,
    output logic                      grant_active
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] BURST = 1'b1;

    logic [0:0]    state;
    logic [GW-1:0] rr_ptr;
    logic [3:0]    beat_cnt;
    logic [3:0]    idle_cnt;

    logic [GW-1:0] sel;
    int unsigned   idx;
    logic          burst;
    logic          g_valid;
    logic          g_last;
    logic          xfer;
    logic [3:0]    beat_inc;
    logic [3:0]    idle_inc;
    logic          burst_end;
    logic [GW-1:0] next_ptr;

    // Scan downward so the lowest offset from rr_ptr wins.
    always_comb begin
        sel = rr_ptr;
        idx = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = (int'(rr_ptr) + k) % NUM_REQ;
            if (req_valid[idx]) sel = GW'(idx);
        end
    end

    assign burst        = (state == BURST);
    assign g_valid      = req_valid[grant_id];
    assign g_last       = req_last[grant_id];
    assign xfer         = burst && g_valid && !fifo_full;
    assign grant_active = burst;
    assign fifo_wr_en   = xfer;
    assign req_ready    = (burst && !fifo_full) ? (NUM_REQ'(1) << grant_id) : '0;
    assign fifo_wr_data = burst ? req_data[int'(grant_id)*DATA_W +: DATA_W] : '0;

    assign beat_inc = (beat_cnt == 4'hF) ? beat_cnt : beat_cnt + 4'd1;
    assign idle_inc = (idle_cnt == 4'hF) ? idle_cnt : idle_cnt + 4'd1;

    // Stalls on fifo_full with valid high neither advance nor clear the idle count.
    assign burst_end = (xfer && (g_last || beat_inc == 4'(MAX_BURST))) ||
                       (burst && !g_valid && idle_inc == 4'(IDLE_TIMEOUT));

    assign next_ptr = (grant_id == GW'(NUM_REQ - 1)) ? '0 : grant_id + GW'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            grant_id <= '0;
            beat_cnt <= '0;
            idle_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req_valid) begin
                        grant_id <= sel;
                        beat_cnt <= '0;
                        idle_cnt <= '0;
                        state    <= BURST;
                    end
                end
                default: begin
                    if (xfer) begin
                        beat_cnt <= beat_inc;
                        idle_cnt <= '0;
                    end else if (!g_valid) begin
                        idle_cnt <= idle_inc;
                    end
                    if (burst_end) begin
                        state  <= IDLE;
                        rr_ptr <= next_ptr;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_rr_wr_arbiter.sv
// tb/tb_fifo_rr_wr_arbiter.sv - directed and randomized checks of fifo_rr_wr_arbiter against a reference model
module tb_fifo_rr_wr_arbiter;

    localparam int N    = 4;
    localparam int W    = 8;
    localparam int MAXB = 4;
    localparam int TO   = 8;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req_valid = '0;
    logic [N-1:0]   req_last = '0;
    logic [N*W-1:0] req_data = '0;
    logic           fifo_full = 1'b0;
    logic [N-1:0]   req_ready;
    logic           fifo_wr_en;
    logic [W-1:0]   fifo_wr_data;
    logic [1:0]     grant_id;
    logic           grant_active;

    fifo_rr_wr_arbiter #(
        .NUM_REQ(N), .DATA_W(W), .MAX_BURST(MAXB), .IDLE_TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_last(req_last), .req_data(req_data),
        .req_ready(req_ready), .fifo_full(fifo_full),
        .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data),
        .grant_id(grant_id), .grant_active(grant_active)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int n_wr = 0;
    logic [W-1:0] wr_log[$];

    // Reference model: who holds the grant, where the pointer sits, beats sent, idle cycles seen.
    int m_busy, m_g, m_ptr, m_beats, m_idles;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_g = 0; m_ptr = 0; m_beats = 0; m_idles = 0;
    endtask

    function automatic logic [N*W-1:0] put(input int i, input logic [W-1:0] b);
        logic [N*W-1:0] r;
        r = '0;
        r[i*W +: W] = b;
        return r;
    endfunction

    task automatic cycle(input logic [N-1:0] v, input logic [N-1:0] l,
                         input logic [N*W-1:0] d, input logic f);
        logic [N-1:0] e_ready;
        logic         e_wr;
        logic [W-1:0] e_data;
        int           found;
        bit           end_b;
        @(negedge clk);
        req_valid = v; req_last = l; req_data = d; fifo_full = f;
        #1;
        e_ready = '0; e_wr = 1'b0; e_data = '0;
        if (m_busy != 0) begin
            if (!f) e_ready[m_g] = 1'b1;
            e_wr   = v[m_g] && !f;
            e_data = d[m_g*W +: W];
        end
        check("ready", req_ready, e_ready);
        check("wr_en", fifo_wr_en, e_wr);
        check("wr_data", fifo_wr_data, e_data);
        check("active", grant_active, m_busy);
        check("grant_id", grant_id, m_g);
        check("full_wr", fifo_wr_en & fifo_full, 0);
        if (fifo_wr_en) begin
            wr_log.push_back(fifo_wr_data);
            n_wr++;
        end
        @(posedge clk);
        if (m_busy == 0) begin
            found = -1;
            for (int k = N - 1; k >= 0; k--)
                if (v[(m_ptr + k) % N]) found = (m_ptr + k) % N;
            if (found >= 0) begin
                m_g = found; m_busy = 1; m_beats = 0; m_idles = 0;
            end
        end else begin
            end_b = 0;
            if (e_wr) begin
                if (m_beats < 15) m_beats++;
                m_idles = 0;
                if (l[m_g] || m_beats == MAXB) end_b = 1;
            end else if (!v[m_g]) begin
                if (m_idles < 15) m_idles++;
                if (m_idles == TO) end_b = 1;
            end
            if (end_b) begin
                m_busy = 0;
                m_ptr  = (m_g + 1) % N;
            end
        end
    endtask

    task automatic apply_reset();
        #2 rst = 1'b1;
        #1;
        check("arst_active", grant_active, 0);
        check("arst_wr_en", fifo_wr_en, 0);
        check("arst_ready", req_ready, 0);
        @(posedge clk);
        #2 rst = 1'b0;
        model_reset();
    endtask

    initial begin
        int dens, fdens;
        logic [N-1:0] v, l;
        model_reset();
        @(negedge clk);
        #1;
        check("rst_active", grant_active, 0);
        check("rst_wr_en", fifo_wr_en, 0);
        check("rst_ready", req_ready, 0);
        check("rst_data", fifo_wr_data, 0);
        check("rst_gid", grant_id, 0);
        @(posedge clk);
        #2 rst = 1'b0;

        // Single burst from requester 2
        cycle(4'b0100, 4'b0000, put(2, 8'hA1), 1'b0);
        #1 check("sb_gid", grant_id, 2);
        check("sb_active", grant_active, 1);
        wr_log.delete();
        cycle(4'b0100, 4'b0000, put(2, 8'hA1), 1'b0);
        cycle(4'b0100, 4'b0000, put(2, 8'hA2), 1'b0);
        cycle(4'b0100, 4'b0100, put(2, 8'hA3), 1'b0);
        check("sb_nwr", wr_log.size(), 3);
        for (int i = 0; i < 3; i++)
            check("sb_data", (i < wr_log.size()) ? {24'h0, wr_log[i]} : 32'hDEAD, 32'hA1 + i);
        #1 check("sb_end", grant_active, 0);

        // Pointer at 3, only requester 1 valid
        cycle(4'b0010, 4'b0000, put(1, 8'h55), 1'b0);
        #1 check("wrap_gid", grant_id, 1);
        cycle(4'b0010, 4'b0010, put(1, 8'h56), 1'b0);
        cycle(4'b1111, 4'b0000, 32'h44332211, 1'b0);
        #1 check("ptr2_gid", grant_id, 2);
        cycle(4'b1111, 4'b0000, 32'h88776655, 1'b0);
        apply_reset();

        // Rotation with everyone valid and no last
        n_wr = 0;
        for (int k = 0; k < 25; k++) begin
            cycle(4'b1111, 4'b0000, $urandom, 1'b0);
            if (k < 24 && (k + 1) % 5 != 0) begin
                #1 check("rot_gid", grant_id, ((k + 1) / 5) % 4);
            end
        end
        check("rot_nwr", n_wr, 20);

        // Backpressure on requester 1
        cycle(4'b0010, 4'b0000, put(1, 8'hB0), 1'b0);
        #1 check("bp_gid", grant_id, 1);
        wr_log.delete();
        cycle(4'b0010, 4'b0000, put(1, 8'hB1), 1'b0);
        for (int i = 0; i < 3; i++) cycle(4'b0010, 4'b0000, put(1, 8'hB2), 1'b1);
        #1 check("bp_active", grant_active, 1);
        cycle(4'b0010, 4'b0000, put(1, 8'hB2), 1'b0);
        cycle(4'b0010, 4'b0000, put(1, 8'hB3), 1'b0);
        cycle(4'b0010, 4'b0000, put(1, 8'hB4), 1'b0);
        check("bp_nwr", wr_log.size(), 4);
        for (int i = 0; i < 4; i++)
            check("bp_data", (i < wr_log.size()) ? {24'h0, wr_log[i]} : 32'hDEAD, 32'hB1 + i);
        #1 check("bp_end", grant_active, 0);

        // Idle timeout on requester 0 while requester 3 waits
        cycle(4'b0001, 4'b0000, put(0, 8'hC1), 1'b0);
        #1 check("to_gid", grant_id, 0);
        cycle(4'b1001, 4'b0000, put(0, 8'hC1), 1'b0);
        for (int j = 0; j < TO; j++) begin
            cycle(4'b1000, 4'b0000, put(3, 8'hD0), 1'b0);
            #1 check("to_active", grant_active, (j < TO - 1) ? 1 : 0);
        end
        cycle(4'b1000, 4'b0000, put(3, 8'hD0), 1'b0);
        #1 check("to_next_gid", grant_id, 3);

        // Randomized traffic with varying density, backpressure and rare resets
        for (int b = 0; b < 40; b++) begin
            case ($urandom_range(0, 2))
                0:       dens = 10;
                1:       dens = 50;
                default: dens = 90;
            endcase
            fdens = $urandom_range(0, 40);
            for (int c = 0; c < 64; c++) begin
                for (int i = 0; i < N; i++) v[i] = ($urandom_range(0, 99) < dens);
                l = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
                cycle(v, l, $urandom, ($urandom_range(0, 99) < fdens));
                if ($urandom_range(0, 499) == 0) apply_reset();
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
